demux_stream: RTL and testbench

Parametrised 1-to-N stream demultiplexer with valid/ready handshaking and one registered holding slot per output channel. It generalises the combinational 1-to-4 demux to arbitrary data width and channel count. It adds backpressure, a broadcast mode and drop accounting for out-of-range selects. It sits between a single producer and N independent consumers that may stall individually.

---
 rtl/demux_stream.sv | 90 +++++++++
 tb/tb_demux_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: 1-to-N valid/ready stream demultiplexer with one holding slot per
// channel, a broadcast mode and a saturating counter of words dropped for bad selects.
module demux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count
);

    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [7:0]                drop_count_q, drop_count_d;
    logic [CHANNELS-1:0]       free;
    logic [CHANNELS-1:0]       load;
    logic                      sel_free;
    logic                      in_range;
    logic                      accept;
    logic                      drop;

    // A draining slot counts as free so a channel can sustain one word per cycle.
    always_comb begin
        free     = ~valid_q | out_ready;
        in_range = ({1'b0, in_sel} < CH_LIM);
        sel_free = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free = free[k];
            end
        end
        in_ready = 1'b0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free;
        end else if (in_range) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
    end

    always_comb begin
        accept  = in_valid & in_ready;
        drop    = accept & ~in_bcast & ~in_range;
        load    = '0;
        valid_d = '0;
        data_d  = data_q;
        for (int k = 0; k < CHANNELS; k++) begin
            load[k]    = accept & (in_bcast | (in_range & (in_sel == SEL_W'(k))));
            valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
            if (load[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
            end
        end
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            data_q       <= '0;
            drop_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: table-driven directed vectors plus a randomised queue-based
// scoreboard for demux_stream, with a 3-channel instance for out-of-range drops.
module tb_demux_stream;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int S  = 2;
    localparam int C3 = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [W-1:0]     in_data;
    logic [S-1:0]     in_sel;
    logic             in_bcast;
    logic             in_valid;
    logic             in_ready;
    logic [C*W-1:0]   out_data;
    logic [C-1:0]     out_valid;
    logic [C-1:0]     out_ready;
    logic [7:0]       drop_count;

    logic [W-1:0]     in3_data;
    logic [S-1:0]     in3_sel;
    logic             in3_bcast;
    logic             in3_valid;
    logic             in3_ready;
    logic [C3*W-1:0]  out3_data;
    logic [C3-1:0]    out3_valid;
    logic [C3-1:0]    out3_ready;
    logic [7:0]       drop3;

    demux_stream #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    demux_stream #(.WIDTH(W), .CHANNELS(C3), .SEL_W(S)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in3_data), .in_sel(in3_sel),
        .in_bcast(in3_bcast), .in_valid(in3_valid), .in_ready(in3_ready),
        .out_data(out3_data), .out_valid(out3_valid), .out_ready(out3_ready),
        .drop_count(drop3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  s;
        logic        b;
        logic        v;
        logic [3:0]  r;
        logic        er;
        logic [3:0]  ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: each channel is a queue of accepted-but-undelivered words.
    logic [7:0] mq [C][$];
    logic [7:0] mdl_last [C];
    int         mdl_drops;
    logic       seen_ready;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [7:0] d, input logic [1:0] s, input logic b,
                                   input logic v, input logic [3:0] r, input logic er,
                                   input logic [3:0] ev, input logic [31:0] ed);
        vec_t t;
        t.d = d; t.s = s; t.b = b; t.v = v; t.r = r;
        t.er = er; t.ev = ev; t.ed = ed;
        return t;
    endfunction

    function automatic logic mdlReady(input logic [1:0] s, input logic b, input logic [3:0] r);
        logic ok;
        ok = 1'b1;
        if (b) begin
            for (int k = 0; k < C; k++) begin
                if (mq[k].size() != 0 && !r[k]) ok = 1'b0;
            end
        end else if (int'(s) < C) begin
            ok = (mq[s].size() == 0) || r[s];
        end
        return ok;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < C; k++) begin
            mq[k].delete();
            mdl_last[k] = 8'h00;
        end
        mdl_drops = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic b,
                                 input logic v, input logic [3:0] r);
        logic exp_ready;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        in_valid  = v;
        out_ready = r;
        #1;
        exp_ready  = mdlReady(s, b, r);
        seen_ready = in_ready;
        compare("in_ready_model", {31'b0, in_ready}, {31'b0, exp_ready});
        @(posedge clk);
        for (int k = 0; k < C; k++) begin
            if (mq[k].size() != 0 && r[k]) void'(mq[k].pop_front());
        end
        if (v && exp_ready) begin
            if (b) begin
                for (int k = 0; k < C; k++) begin
                    mq[k].push_back(d);
                    mdl_last[k] = d;
                end
            end else if (int'(s) < C) begin
                mq[s].push_back(d);
                mdl_last[s] = d;
            end else if (mdl_drops < 255) begin
                mdl_drops++;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        for (int k = 0; k < C; k++) begin
            compare($sformatf("%s_valid%0d", tag, k), {31'b0, out_valid[k]},
                    {31'b0, (mq[k].size() != 0)});
            compare($sformatf("%s_data%0d", tag, k), {24'b0, out_data[k*W +: W]},
                    {24'b0, mdl_last[k]});
        end
        compare($sformatf("%s_drops", tag), {24'b0, drop_count}, mdl_drops);
    endtask

    task automatic runVec(input string tag, input int i);
        applyStimulus(tbl[i].d, tbl[i].s, tbl[i].b, tbl[i].v, tbl[i].r);
        compare($sformatf("%s%0d_ready", tag, i), {31'b0, seen_ready}, {31'b0, tbl[i].er});
        compare($sformatf("%s%0d_valid", tag, i), {28'b0, out_valid}, {28'b0, tbl[i].ev});
        compare($sformatf("%s%0d_data", tag, i), out_data, tbl[i].ed);
        checkOutput($sformatf("%s%0d", tag, i));
    endtask

    initial begin
        in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
        in3_data = '0; in3_sel = '0; in3_bcast = 1'b0; in3_valid = 1'b0; out3_ready = 3'b111;

        #1 rst_n = 1'b0;
        #2;
        compare("reset_in_ready", {31'b0, in_ready}, 32'd0);
        compare("reset_out_valid", {28'b0, out_valid}, 32'd0);
        compare("reset_out_data", out_data, 32'd0);
        compare("reset_drops", {24'b0, drop_count}, 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep, backpressure on ch2, then broadcast stalled by ch2.
        tbl.push_back(mkVec(8'hA0, 2'd0, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h000000A0));
        tbl.push_back(mkVec(8'hA1, 2'd1, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0));
        tbl.push_back(mkVec(8'hA2, 2'd2, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0));
        tbl.push_back(mkVec(8'hA3, 2'd3, 1'b0, 1'b1, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0));
        tbl.push_back(mkVec(8'h00, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0));
        tbl.push_back(mkVec(8'h55, 2'd2, 1'b0, 1'b1, 4'hB, 1'b1, 4'b0100, 32'hA355A1A0));
        tbl.push_back(mkVec(8'h99, 2'd2, 1'b0, 1'b0, 4'hB, 1'b0, 4'b0100, 32'hA355A1A0));
        tbl.push_back(mkVec(8'h66, 2'd2, 1'b0, 1'b1, 4'hB, 1'b0, 4'b0100, 32'hA355A1A0));
        tbl.push_back(mkVec(8'h77, 2'd1, 1'b0, 1'b1, 4'hB, 1'b1, 4'b0110, 32'hA35577A0));
        tbl.push_back(mkVec(8'h66, 2'd2, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0100, 32'hA36677A0));
        tbl.push_back(mkVec(8'h00, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hA36677A0));
        tbl.push_back(mkVec(8'h3C, 2'd0, 1'b1, 1'b1, 4'hB, 1'b1, 4'b1111, 32'h3C3C3C3C));
        tbl.push_back(mkVec(8'h5A, 2'd0, 1'b1, 1'b1, 4'hB, 1'b0, 4'b0100, 32'h3C3C3C3C));
        tbl.push_back(mkVec(8'h5A, 2'd0, 1'b1, 1'b1, 4'hB, 1'b0, 4'b0100, 32'h3C3C3C3C));
        tbl.push_back(mkVec(8'h5A, 2'd0, 1'b1, 1'b1, 4'hF, 1'b1, 4'b1111, 32'h5A5A5A5A));
        tbl.push_back(mkVec(8'h00, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h5A5A5A5A));

        for (int i = 0; i < tbl.size(); i++) runVec("vec", i);

        // Out-of-range selects on the 3-channel instance.
        in3_sel   = 2'd3;
        in3_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in3_data = 8'($urandom);
            #1;
            compare("oor_ready", {31'b0, in3_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            compare("oor_valid", {29'b0, out3_valid}, 32'd0);
            compare("oor_drops", {24'b0, drop3}, (i + 1 > 255) ? 255 : i + 1);
        end
        in3_sel  = 2'd2;
        in3_data = 8'h42;
        #1;
        compare("oor_inrange_ready", {31'b0, in3_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in3_valid = 1'b0;
        compare("oor_inrange_valid", {29'b0, out3_valid}, 32'b100);
        compare("oor_inrange_data", {24'b0, out3_data[2*W +: W]}, 32'h42);
        compare("oor_drops_final", {24'b0, drop3}, 32'd255);

        // Asynchronous reset between clock edges while every slot is full.
        applyStimulus(8'hC3, 2'd0, 1'b1, 1'b1, 4'h0);
        checkOutput("preload");
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; in_bcast = 1'b0; in_sel = 2'd0; out_ready = 4'hF;
        #1;
        compare("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        compare("midrst_out_valid", {28'b0, out_valid}, 32'd0);
        compare("midrst_out_data", out_data, 32'd0);
        compare("midrst_drops", {24'b0, drop_count}, 32'd0);
        compare("midrst_drops3", {24'b0, drop3}, 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) runVec("resweep", i);

        for (int n = 0; n < 2000; n++) begin
            applyStimulus(8'($urandom), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                          4'($urandom));
            checkOutput("rand");
        end
        for (int n = 0; n < 2; n++) begin
            applyStimulus(8'h00, 2'd0, 1'b0, 1'b0, 4'hF);
            checkOutput("drain");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
